pulse_stat: RTL

Pulse-statistics stage directly downstream of the registered AND gate in the counter project. It consumes the gate's registered 1-bit output and detects rising edges, rejecting glitches shorter than MIN_HIGH cycles. It counts qualified pulses and records the width of the last qualified pulse. It also raises a one-cycle hit flag when the count reaches a programmable target.

---
 rtl/pulse_stat.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pulse_stat.sv
// Pulse statistics: glitch-filtered rising-edge detection,
// pulse count, last pulse width and a one-shot target hit.
module pulse_stat #(
  parameter int CNT_W    = 8,
  parameter int MIN_HIGH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] width_last,
  output logic             hit,
  output logic             ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAXV = '1;
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MINH = CNT_W'(MIN_HIGH);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic             din_d_q;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             ovf_q, ovf_d;
  logic             hit_q, hit_d;
  logic             rise;
  logic             qual;
  logic [CNT_W-1:0] wcnt_inc;
  logic [CNT_W-1:0] count_inc;

  // Next-state: pulse tracking FSM and statistics update
  always_comb begin
    rise      = din & ~din_d_q;
    wcnt_inc  = (wcnt_q == MAXV) ? MAXV : wcnt_q + ONE;
    count_inc = count_q + ONE;
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    width_d   = width_q;
    qual      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && rise) begin
          wcnt_d = ONE;
          if (MIN_HIGH == 1) begin
            state_d = HOLD;
            qual    = 1'b1;
          end else begin
            state_d = ARM;
          end
        end
      end
      ARM: begin
        if (!en || !din) begin
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == MINH) begin
            state_d = HOLD;
            qual    = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!en) begin
          state_d = IDLE;
        end else if (din) begin
          wcnt_d = wcnt_inc;
        end else begin
          width_d = wcnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q;
    ovf_d   = ovf_q;
    hit_d   = 1'b0;
    if (qual) begin
      if (count_q != MAXV) begin
        count_d = count_inc;
        hit_d   = (count_inc == target);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers; edge history survives clr, stats do not
  always_ff @(posedge clk) begin
    if (reset) begin
      din_d_q <= 1'b1;
      state_q <= IDLE;
      wcnt_q  <= '0;
      count_q <= '0;
      width_q <= '0;
      ovf_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      din_d_q <= din;
      if (clr) begin
        state_q <= IDLE;
        wcnt_q  <= '0;
        count_q <= '0;
        width_q <= '0;
        ovf_q   <= 1'b0;
        hit_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
        count_q <= count_d;
        width_q <= width_d;
        ovf_q   <= ovf_d;
        hit_q   <= hit_d;
      end
    end
  end

  assign count      = count_q;
  assign width_last = width_q;
  assign hit        = hit_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q != IDLE);

endmodule
